toggle_hs_rx: RTL

- Destination-domain end of a toggle request/acknowledge CDC link.
- The remote sender flips Req_tgl_in after placing a stable word on Data_in. This block:
  - synchronizes the toggle,
  - captures the word,
  - presents it on a valid/ready interface,
  - flips Ack_tgl_out once the word is consumed.
- Sits at EOC/periphery boundaries where multi-bit config or status words cross clock domains.

---
 rtl/toggle_hs_pkg.sv | 22 ++
 rtl/toggle_hs_rx_bit_sync.sv | 23 ++
 rtl/toggle_hs_rx.sv | 117 +++++++++++
 3 files changed

// File: rtl/toggle_hs_pkg.sv
// Shared types and defaults for the toggle request/acknowledge CDC receiver.
package toggle_hs_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 16;

  // Wide enough to count INIT cycles for the deepest legal synchronizer (4 stages).
  localparam int INIT_CNT_W = 3;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    HOLD
  } state_t;

  // INIT lasts one cycle longer than the synchronizer is deep, so req_d is settled.
  function automatic int init_len(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/toggle_hs_rx_bit_sync.sv
// Single-bit multi-flop synchronizer; latency STAGES cycles, no backpressure.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/toggle_hs_rx.sv
// Receive end of a toggle req/ack CDC link; word valid SYNC_STAGES+1 cycles after Req flips.
// Ack toggles back only when the word is consumed (Valid_out & Ready_in), giving end-to-end backpressure.
module toggle_hs_rx
  import toggle_hs_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              Clk,
  input  logic              Reset_b,
  input  logic              Req_tgl_in,
  input  logic [DATA_W-1:0] Data_in,
  output logic              Ack_tgl_out,
  output logic [DATA_W-1:0] Data_out,
  output logic              Valid_out,
  input  logic              Ready_in,
  output logic              Proto_err,
  output logic [CNT_W-1:0]  Xfer_cnt
);

  localparam int                    INIT_LEN  = init_len(SYNC_STAGES);
  localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(INIT_LEN - 1);

  logic req_s;
  logic req_d;
  logic evt;

  state_t                state, state_nxt;
  logic [INIT_CNT_W-1:0] init_cnt, init_cnt_nxt;
  logic [DATA_W-1:0]     data_nxt;
  logic                  valid_nxt;
  logic                  ack_nxt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  err_nxt;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk  (Clk),
    .rst_n(Reset_b),
    .d    (Req_tgl_in),
    .q    (req_s)
  );

  // The detect register updates every cycle, so any toggle is consumed exactly once.
  always_ff @(posedge Clk or negedge Reset_b) begin
    if (!Reset_b) begin
      req_d <= 1'b0;
    end else begin
      req_d <= req_s;
    end
  end

  assign evt = req_s ^ req_d;

  always_ff @(posedge Clk or negedge Reset_b) begin
    if (!Reset_b) begin
      state       <= INIT;
      init_cnt    <= '0;
      Data_out    <= '0;
      Valid_out   <= 1'b0;
      Ack_tgl_out <= 1'b0;
      Xfer_cnt    <= '0;
      Proto_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      init_cnt    <= init_cnt_nxt;
      Data_out    <= data_nxt;
      Valid_out   <= valid_nxt;
      Ack_tgl_out <= ack_nxt;
      Xfer_cnt    <= cnt_nxt;
      Proto_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    data_nxt     = Data_out;
    valid_nxt    = Valid_out;
    ack_nxt      = Ack_tgl_out;
    cnt_nxt      = Xfer_cnt;
    err_nxt      = Proto_err;
    case (state)
      // A Req level already high at reset release settles here and is not a transfer.
      INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_nxt = IDLE;
        end else begin
          init_cnt_nxt = init_cnt + INIT_CNT_W'(1);
        end
      end
      IDLE: begin
        if (evt) begin
          data_nxt  = Data_in;
          valid_nxt = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // A second toggle before Ack is dropped; the held word still completes.
        if (evt) begin
          err_nxt = 1'b1;
        end
        if (Ready_in) begin
          valid_nxt = 1'b0;
          ack_nxt   = ~Ack_tgl_out;
          cnt_nxt   = Xfer_cnt + CNT_W'(1);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

endmodule
